// File: rtl/reg_file_mp.sv
// Multi-port register file for a pipelined datapath.
// Two write lanes (lane 1 wins a collision), NRP combinational read ports with
// optional same-cycle write forwarding, and a per-register pending scoreboard.
// x0 is hardwired to zero and has no storage.
module reg_file_mp #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int NRP        = 2,
    parameter int RESET_MODE = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRP*AW-1:0]     rs_sel,
    output logic [NRP*XLEN-1:0]   rs_data,
    output logic [NRP-1:0]        rs_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         rd0_sel,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         rd1_sel,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic [NREG-1:0]       pending
);

    localparam bit BYP = (BYPASS != 0);

    logic [NREG-1:1][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0][XLEN-1:0] regs_all;
    logic [NREG-1:0]           pending_q, pending_d;
    logic                      wr0_ok, wr1_ok;

    // A write to x0 is a no-op everywhere: storage, scoreboard and forwarding.
    assign wr0_ok = we0 && (rd0_sel != '0);
    assign wr1_ok = we1 && (rd1_sel != '0);

    // Next-state for storage and scoreboard; lane 1 applied after lane 0 so it
    // wins a same-register collision, and issue applied last so a new producer
    // keeps the bit set even when an older one retires on the same edge.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int i = 1; i < NREG; i++) begin
            if (wr0_ok && rd0_sel == AW'(i)) begin
                regs_d[i]    = wd0;
                pending_d[i] = 1'b0;
            end
            if (wr1_ok && rd1_sel == AW'(i)) begin
                regs_d[i]    = wd1;
                pending_d[i] = 1'b0;
            end
        end
        if (issue_valid && issue_rd != '0)
            pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // State registers; reset loads init values and drops any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++)
                regs_q[i] <= (RESET_MODE == 1) ? XLEN'(i) : '0;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    // Full read view with x0 tied to zero so a select of 0 needs no special case.
    assign regs_all = {regs_q, {XLEN{1'b0}}};
    assign pending  = pending_q;

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   sel;
        logic            hit0, hit1;
        logic [XLEN-1:0] stored;

        assign sel    = rs_sel[k*AW +: AW];
        assign stored = regs_all[sel];
        // Forwarding is suppressed under reset so reads show the reset state.
        assign hit1   = BYP && !reset && wr1_ok && (rd1_sel == sel);
        assign hit0   = BYP && !reset && wr0_ok && (rd0_sel == sel);

        assign rs_data[k*XLEN +: XLEN] = hit1 ? wd1 : (hit0 ? wd0 : stored);
        // A forwarded value is the producer's result, so it is no longer busy.
        assign rs_busy[k] = pending_q[sel] & ~(hit0 | hit1);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: two instances (forwarding on / off) share
// stimulus; the driver pushes expected outputs from an array-based model and a
// negedge monitor pops and compares.
module tb_reg_file_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [AW-1:0]       sel0, sel1;
    logic [NRP*AW-1:0]   rs_sel;
    logic                we0, we1, issue_valid;
    logic [AW-1:0]       rd0_sel, rd1_sel, issue_rd;
    logic [XLEN-1:0]     wd0, wd1;
    logic [NRP*XLEN-1:0] rs_data_b, rs_data_n;
    logic [NRP-1:0]      rs_busy_b, rs_busy_n;
    logic [NREG-1:0]     pending_b, pending_n;

    assign rs_sel = {sel1, sel0};

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .RESET_MODE(1), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .rs_sel(rs_sel), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
        .we0(we0), .rd0_sel(rd0_sel), .wd0(wd0), .we1(we1), .rd1_sel(rd1_sel), .wd1(wd1),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending_b));

    reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .RESET_MODE(1), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .rs_sel(rs_sel), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
        .we0(we0), .rd0_sel(rd0_sel), .wd0(wd0), .we1(we1), .rd1_sel(rd1_sel), .wd1(wd1),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending_n));

    typedef struct {
        logic [NRP*XLEN-1:0] d_b, d_n;
        logic [NRP-1:0]      b_b, b_n;
        logic [NREG-1:0]     p;
    } exp_t;

    exp_t            q[$];
    logic [XLEN-1:0] mem [NREG];
    bit              pend [NREG];
    int              n_total = 0;
    int              n_pass  = 0;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mem[i]  = XLEN'(i);
            pend[i] = 1'b0;
        end
    endtask

    function automatic bit wr_hit(bit byp, logic [AW-1:0] s, output logic [XLEN-1:0] v);
        v = '0;
        if (!byp || reset || s == 0) return 1'b0;
        if (we1 && rd1_sel == s) begin v = wd1; return 1'b1; end
        if (we0 && rd0_sel == s) begin v = wd0; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(bit byp, logic [AW-1:0] s);
        logic [XLEN-1:0] v;
        if (s == 0) return '0;
        if (wr_hit(byp, s, v)) return v;
        return mem[s];
    endfunction

    function automatic logic exp_busy(bit byp, logic [AW-1:0] s);
        logic [XLEN-1:0] v;
        if (s == 0 || reset) return 1'b0;
        if (wr_hit(byp, s, v)) return 1'b0;
        return pend[s];
    endfunction

    // Push what the outputs must show this cycle, then advance one edge and
    // apply the architectural effect of the inputs to the model.
    task automatic cycle();
        exp_t e;
        logic [AW-1:0] s;
        if (reset) model_reset();
        for (int k = 0; k < NRP; k++) begin
            s = (k == 0) ? sel0 : sel1;
            e.d_b[k*XLEN +: XLEN] = exp_data(1'b1, s);
            e.d_n[k*XLEN +: XLEN] = exp_data(1'b0, s);
            e.b_b[k] = exp_busy(1'b1, s);
            e.b_n[k] = exp_busy(1'b0, s);
        end
        for (int i = 0; i < NREG; i++) e.p[i] = pend[i];
        q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            if (we0 && rd0_sel != 0) begin mem[rd0_sel] = wd0; pend[rd0_sel] = 1'b0; end
            if (we1 && rd1_sel != 0) begin mem[rd1_sel] = wd1; pend[rd1_sel] = 1'b0; end
            if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rs_data_byp", 64'(rs_data_b), 64'(e.d_b));
            chk("rs_data_nobyp", 64'(rs_data_n), 64'(e.d_n));
            chk("rs_busy_byp", 64'(rs_busy_b), 64'(e.b_b));
            chk("rs_busy_nobyp", 64'(rs_busy_n), 64'(e.b_n));
            chk("pending_byp", 64'(pending_b), 64'(e.p));
            chk("pending_nobyp", 64'(pending_n), 64'(e.p));
        end
    end

    initial begin
        reset = 1'b1;
        we0 = 0; we1 = 0; issue_valid = 0;
        rd0_sel = 0; rd1_sel = 0; issue_rd = 0; wd0 = 0; wd1 = 0;
        sel0 = 1; sel1 = 2;
        model_reset();
        @(posedge clk); #1;
        cycle();                                   // in reset: {2,1}
        reset = 1'b0; cycle();                     // after reset: {2,1}, nothing pending

        // write port driven but disabled
        rd0_sel = 10; wd0 = 32'hDEADBEEF; sel0 = 10; sel1 = 0; cycle();
        cycle();

        // two lanes, two registers, same edge
        we0 = 1; rd0_sel = 7; wd0 = 32'h12345678;
        we1 = 1; rd1_sel = 9; wd1 = 32'hCAFEBABE; sel0 = 7; sel1 = 9; cycle();
        we0 = 0; we1 = 0; cycle();

        // both lanes to x3: lane 1 wins
        we0 = 1; rd0_sel = 3; wd0 = 32'hDEADBEEF;
        we1 = 1; rd1_sel = 3; wd1 = 32'h0BADF00D; sel0 = 3; sel1 = 3; cycle();
        we0 = 0; we1 = 0; cycle();

        // x0 write ignored
        we1 = 1; rd1_sel = 0; wd1 = 32'hFFFFFFFF; sel0 = 0; sel1 = 0; cycle();
        we1 = 0; cycle();

        // same-cycle forwarding vs stored value
        we0 = 1; rd0_sel = 10; wd0 = 32'hA5A5A5A5; sel0 = 10; sel1 = 10; cycle();
        we0 = 0; cycle();

        // scoreboard: issue, retire, issue+retire on one edge, issue to x0
        issue_valid = 1; issue_rd = 12; sel0 = 12; sel1 = 12; cycle();
        issue_valid = 0; cycle();
        we1 = 1; rd1_sel = 12; wd1 = 32'h00001111; cycle();
        we1 = 0; cycle();
        issue_valid = 1; issue_rd = 12; we0 = 1; rd0_sel = 12; wd0 = 32'h00002222; cycle();
        issue_valid = 0; we0 = 0; cycle();
        issue_valid = 1; issue_rd = 0; sel0 = 0; cycle();
        issue_valid = 0; cycle();

        // reset raised mid-cycle while a write to x5 is pending
        we0 = 1; rd0_sel = 5; wd0 = 32'h55555555; sel0 = 5; sel1 = 7;
        #2 reset = 1'b1; cycle();
        reset = 1'b0; we0 = 0; cycle();

        // randomized traffic over a narrow register range to force collisions
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 63) == 0);
            we0         = 1'($urandom_range(0, 1));
            we1         = 1'($urandom_range(0, 1));
            issue_valid = 1'($urandom_range(0, 1));
            rd0_sel     = AW'($urandom_range(0, 15));
            rd1_sel     = AW'($urandom_range(0, 15));
            issue_rd    = AW'($urandom_range(0, 15));
            sel0        = AW'($urandom_range(0, 15));
            sel1        = AW'($urandom_range(0, 15));
            wd0         = $urandom;
            wd1         = $urandom;
            cycle();
        end
        reset = 0; we0 = 0; we1 = 0; issue_valid = 0;

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the single-cycle register file. Configurable data width, register count and number of read ports. Adds a second write port with defined collision priority, optional same-cycle write-to-read bypass, and a per-register pending scoreboard for a multi-issue or pipelined datapath. Sits between decode (read selects and issue) and writeback (two retire lanes).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; must be a power of 2 and at least 2; AW = log2(NREG)
NRP, 2, number of read ports
RESET_MODE, 1, 1 = register i resets to value i (x0 = 0); 0 = all registers reset to 0
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored contents only

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rs_sel  in  NRP*AW  read selects; port k at [k*AW +: AW]
rs_data  out  NRP*XLEN  read data; port k at [k*XLEN +: XLEN]
rs_busy  out  NRP  pending flag of the register addressed by each read port
we0  in  1  write enable, lane 0
rd0_sel  in  AW  write address, lane 0
wd0  in  XLEN  write data, lane 0
we1  in  1  write enable, lane 1
rd1_sel  in  AW  write address, lane 1
wd1  in  XLEN  write data, lane 1
issue_valid  in  1  marks issue_rd as having an in-flight producer
issue_rd  in  AW  destination of the issued instruction
pending  out  NREG  scoreboard vector; bit i is set when register i has an in-flight producer

Behaviour:
- Reset (async, any time including mid-write):
  - Registers load their init values immediately: i under RESET_MODE=1, 0 under RESET_MODE=0.
  - pending clears to 0.
  - Writes and issues sampled while reset is high are discarded.
  - Outputs during and after reset are combinational from the reset state: rs_data[k] = init(rs_sel[k]); rs_busy = 0.
- x0:
  - Always reads 0.
  - Writes to x0 are ignored and never bypassed.
  - issue_rd = 0 never sets pending[0].
- Writes:
  - Take effect on the rising edge when weN = 1 and rdN_sel != 0.
  - Both lanes may write different registers in the same cycle.
  - If both lanes target the same register, lane 1 wins.
- Reads:
  - Combinational, zero latency.
  - BYPASS=1: if rs_sel[k] != 0 matches an active write this cycle, rs_data[k] = that write data (lane 1 has priority over lane 0); otherwise the stored value.
  - BYPASS=0: always the stored value; a write becomes visible the cycle after the edge.
- Scoreboard, evaluated on the rising edge:
  - A write from either lane clears pending[rd].
  - issue_valid sets pending[issue_rd].
  - Issue and write to the same register on the same edge: the set wins, because the newer producer is in flight.
  - issue_valid to a register whose bit is already set leaves it set; no counting.
- rs_busy[k] = pending[rs_sel[k]] & ~hit, where hit = active write to rs_sel[k] this cycle and BYPASS=1. rs_busy[k] = 0 when rs_sel[k] = 0.
- All read ports are independent. Any number of ports may select the same register.
- Storage: flops with NREG-1 physical registers; x0 is not stored.

Test Plan:
- Reset: pulse reset for 10 ns with RESET_MODE=1, then rs_sel = {2,1} -> rs_data = {2,1}, pending = 0, rs_busy = 0. Assert reset mid-cycle while we0=1 to x5 -> x5 reads 5 and the write is lost.
- Dual write: lane0 writes x7 = 12345678 and lane1 writes x9 = CAFEBABE on the same edge -> next cycle x7 = 12345678, x9 = CAFEBABE. Both lanes target x3 with DEADBEEF and 0BADF00D -> x3 = 0BADF00D.
- x0 protection: we1=1, rd1_sel=0, wd1=FFFFFFFF; read x0 on both ports -> 0 in the same cycle and the next.
- Bypass: BYPASS=1, we0 to x10 = A5A5A5A5, rs_sel[0] = 10 in the same cycle -> rs_data[0] = A5A5A5A5 before the edge. With BYPASS=0, the same stimulus -> reads A (old value) until after the edge.
- Scoreboard: issue x12 -> pending[12] = 1 next cycle and rs_busy = 1 when x12 is read. Lane1 write to x12 -> rs_busy = 0 in the write cycle (BYPASS=1) and pending[12] clears after the edge. Issue and write x12 on the same edge -> pending[12] stays 1.
- Write disabled: we0 = we1 = 0 with rd0_sel = 10, wd0 = DEADBEEF -> x10 still reads A and pending is unchanged.
